hash_msg_feeder: RTL and testbench



---
 rtl/hash_msg_feeder_if.sv | 26 ++
 rtl/hash_msg_feeder.sv | 169 ++++++++++++++++
 tb/tb_hash_msg_feeder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hash_msg_feeder_if.sv
// Host byte stream and hash-core message port of the message feeder.
// slave = feeder view, master = host/core side view.
`timescale 1ns/1ps
interface hash_msg_feeder_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        M_valid;
    logic [7:0]  message;
    logic [63:0] counter;
    logic        hash_ready;
    logic        busy;
    logic        msg_done;
    logic        overflow_err;

    modport slave (
        input  in_valid, in_data, in_last, hash_ready,
        output in_ready, M_valid, message, counter, busy, msg_done, overflow_err
    );

    modport master (
        output in_valid, in_data, in_last, hash_ready,
        input  in_ready, M_valid, message, counter, busy, msg_done, overflow_err
    );
endinterface

// File: rtl/hash_msg_feeder.sv
// Buffers one host message, then feeds it to the hash core one byte every
// BYTE_GAP cycles and waits for the digest before taking the next message.
`timescale 1ns/1ps
module hash_msg_feeder #(
    parameter int DEPTH    = 64,
    parameter int BYTE_GAP = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    hash_msg_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(BYTE_GAP + 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_DROP,
        S_ISSUE,
        S_GAP,
        S_WAIT
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_buf [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    // One bit wider than the buffer index so a full DEPTH message can be
    // compared against len without the pointer wrapping to zero.
    logic [LW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_len;
    logic [GW-1:0]  r_gap;
    logic [63:0]    r_counter;
    logic [7:0]     r_msg_last;
    logic           r_msg_done;
    logic           r_ovf;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_room;
    logic           w_issue_done;
    logic           w_store;
    logic [LW-1:0]  w_len_inc;
    logic [GW-1:0]  w_gap_nxt;
    logic [7:0]     w_rd_byte;
    logic           w_m_valid;
    logic           w_busy;

    assign w_in_ready   = (r_state == S_COLLECT) || (r_state == S_DROP);
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_room       = (r_len != LW'(DEPTH));
    assign w_issue_done = (r_rd_ptr == r_len);
    assign w_store      = w_accept && (r_state == S_COLLECT) && w_room;
    assign w_len_inc    = r_len + LW'(1);
    assign w_gap_nxt    = r_gap - GW'(1);
    assign w_rd_byte    = r_buf[r_rd_ptr[AW-1:0]];

    always_comb begin
        w_state_nxt = r_state;
        w_m_valid   = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_COLLECT: begin
                if (w_accept) begin
                    if (w_room && bus.in_last)
                        w_state_nxt = S_ISSUE;
                    else if (!w_room && !bus.in_last)
                        w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (w_accept && bus.in_last)
                    w_state_nxt = S_COLLECT;
            end
            S_ISSUE: begin
                w_m_valid   = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                w_busy = 1'b1;
                // GAP lasts BYTE_GAP-1 cycles so ISSUE-to-ISSUE is BYTE_GAP.
                if (w_gap_nxt == '0)
                    w_state_nxt = w_issue_done ? S_WAIT : S_ISSUE;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (bus.hash_ready)
                    w_state_nxt = S_COLLECT;
            end
            default: w_state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_COLLECT;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_len      <= '0;
            r_gap      <= '0;
            r_counter  <= '0;
            r_msg_last <= '0;
            r_msg_done <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_msg_done <= 1'b0;
            r_ovf      <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        if (w_room) begin
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                            r_len    <= w_len_inc;
                            if (bus.in_last)
                                r_counter <= 64'(w_len_inc);
                        end else if (bus.in_last) begin
                            r_ovf    <= 1'b1;
                            r_len    <= '0;
                            r_wr_ptr <= '0;
                        end
                    end
                end
                S_DROP: begin
                    if (w_accept && bus.in_last) begin
                        r_ovf    <= 1'b1;
                        r_len    <= '0;
                        r_wr_ptr <= '0;
                    end
                end
                S_ISSUE: begin
                    r_msg_last <= w_rd_byte;
                    r_rd_ptr   <= r_rd_ptr + LW'(1);
                    r_gap      <= GW'(BYTE_GAP - 1);
                end
                S_GAP: begin
                    r_gap <= w_gap_nxt;
                end
                S_WAIT: begin
                    if (bus.hash_ready) begin
                        r_msg_done <= 1'b1;
                        r_rd_ptr   <= '0;
                        r_wr_ptr   <= '0;
                        r_len      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: only written bytes are ever read.
    always_ff @(posedge clk) begin
        if (w_store)
            r_buf[r_wr_ptr] <= bus.in_data;
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.M_valid      = w_m_valid;
    assign bus.busy         = w_busy;
    assign bus.message      = (r_state == S_ISSUE) ? w_rd_byte : r_msg_last;
    assign bus.counter      = r_counter;
    assign bus.msg_done     = r_msg_done;
    assign bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder: host byte driver, M_valid monitor and
// hand-computed expectations for each message scenario.
`timescale 1ns/1ps
module tb_hash_msg_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   ovf_n = 0;
    logic [7:0]  byte_q [$];
    int          cyc_q  [$];
    logic [63:0] cnt_q  [$];

    hash_msg_feeder_if bus();

    hash_msg_feeder #(.DEPTH(64), .BYTE_GAP(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.M_valid) begin
            byte_q.push_back(bus.message);
            cyc_q.push_back(cyc);
            cnt_q.push_back(bus.counter);
        end
        if (bus.overflow_err) ovf_n++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    task automatic clear_q();
        byte_q.delete();
        cyc_q.delete();
        cnt_q.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 2000);
        if (!bus.in_ready) chk("send_timeout", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input string tag);
        int t = 0;
        while (byte_q.size() < n && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        if (byte_q.size() < n) chk({tag, "_timeout"}, byte_q.size(), n);
    endtask

    // Called in the cycle of the last M_valid pulse; core answers 8 cycles on.
    task automatic finish_msg(input string tag);
        repeat (8) @(posedge clk);
        #1 bus.hash_ready = 1'b1;
        @(posedge clk); #1 bus.hash_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done"},  bus.msg_done, 1);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        int ovf0;
        int bad;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.hash_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready",   bus.in_ready, 1);
        chk("rst_mvalid",  bus.M_valid, 0);
        chk("rst_message", bus.message, 0);
        chk("rst_counter", bus.counter, 0);
        chk("rst_busy",    bus.busy, 0);
        chk("rst_done",    bus.msg_done, 0);
        chk("rst_ovf",     bus.overflow_err, 0);

        // single byte: M_valid in the cycle right after the in_last accept
        @(posedge clk); #1 clear_q();
        send(8'h61, 1'b1);
        @(negedge clk);
        chk("one_mvalid",  bus.M_valid, 1);
        chk("one_message", bus.message, 8'h61);
        chk("one_counter", bus.counter, 1);
        chk("one_busy",    bus.busy, 1);
        chk("one_ready",   bus.in_ready, 0);
        finish_msg("one");
        chk("one_npulse",  byte_q.size(), 1);

        // "abc" back to back
        @(posedge clk); #1 clear_q();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        wait_pulses(3, "abc");
        chk("abc_b0",   byte_q[0], 8'h61);
        chk("abc_b1",   byte_q[1], 8'h62);
        chk("abc_b2",   byte_q[2], 8'h63);
        chk("abc_gap1", cyc_q[1] - cyc_q[0], 6);
        chk("abc_gap2", cyc_q[2] - cyc_q[1], 6);
        chk("abc_cnt0", cnt_q[0], 3);
        chk("abc_cnt2", cnt_q[2], 3);
        chk("abc_msg_hold", bus.message, 8'h63);
        finish_msg("abc");
        chk("abc_cnt_after", bus.counter, 3);

        // exactly DEPTH bytes
        @(posedge clk); #1 clear_q();
        ovf0 = ovf_n;
        for (int i = 0; i < 64; i++) send(8'(i), i == 63);
        wait_pulses(64, "full");
        chk("full_npulse", byte_q.size(), 64);
        bad = 0;
        for (int i = 0; i < byte_q.size(); i++)
            if (byte_q[i] !== 8'(i) || cnt_q[i] !== 64'd64) bad++;
        chk("full_bytes", bad, 0);
        chk("full_cnt", bus.counter, 64);
        chk("full_ovf", ovf_n - ovf0, 0);
        finish_msg("full");

        // DEPTH+1 bytes: discarded, then a normal 2-byte message
        @(posedge clk); #1 clear_q();
        ovf0 = ovf_n;
        for (int i = 0; i < 65; i++) send(8'(i), i == 64);
        @(negedge clk);
        chk("ovf_pulse", bus.overflow_err, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("ovf_once",   ovf_n - ovf0, 1);
        chk("ovf_nopulse", byte_q.size(), 0);
        chk("ovf_ready",  bus.in_ready, 1);
        send(8'hAA, 1'b0);
        send(8'h55, 1'b1);
        wait_pulses(2, "post");
        chk("post_b0",  byte_q[0], 8'hAA);
        chk("post_b1",  byte_q[1], 8'h55);
        chk("post_cnt", cnt_q[1], 2);
        finish_msg("post");

        // DEPTH bytes then DROP path: 66 bytes, extra non-last byte enters DROP
        @(posedge clk); #1 clear_q();
        ovf0 = ovf_n;
        for (int i = 0; i < 66; i++) send(8'(i), i == 65);
        repeat (10) @(posedge clk);
        #1;
        chk("drop_once",   ovf_n - ovf0, 1);
        chk("drop_nopulse", byte_q.size(), 0);

        // host valid gaps, then a byte offered while busy is stalled
        @(posedge clk); #1 clear_q();
        send(8'h11, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h44;
        bus.in_last  = 1'b1;
        @(negedge clk);
        chk("stall_ready", bus.in_ready, 0);
        fork
            send(8'h44, 1'b1);
            begin
                wait_pulses(3, "gaps");
                finish_msg("gaps");
            end
        join
        chk("gaps_b0",  byte_q[0], 8'h11);
        chk("gaps_b1",  byte_q[1], 8'h22);
        chk("gaps_b2",  byte_q[2], 8'h33);
        chk("gaps_cnt", cnt_q[2], 3);
        wait_pulses(4, "late");
        chk("late_b",   byte_q[3], 8'h44);
        chk("late_cnt", cnt_q[3], 1);
        finish_msg("late");

        // reset in GAP after the 2nd of 4 bytes
        @(posedge clk); #1 clear_q();
        for (int i = 1; i <= 4; i++) send(8'(i), i == 4);
        wait_pulses(2, "mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_mvalid",  bus.M_valid, 0);
        chk("mid_busy",    bus.busy, 0);
        chk("mid_ready",   bus.in_ready, 1);
        chk("mid_counter", bus.counter, 0);
        chk("mid_message", bus.message, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_npulse", byte_q.size(), 2);
        clear_q();
        send(8'h7E, 1'b1);
        @(negedge clk);
        chk("new_mvalid",  bus.M_valid, 1);
        chk("new_message", bus.message, 8'h7E);
        chk("new_counter", bus.counter, 1);
        finish_msg("new");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
